// File: rtl/tia_hphase_gen.sv
// Horizontal phase generator and polynomial line counter for a TIA-style timing chain.
// A one-hot 4-phase ring drives glitch-free phi1/phi2 strobes; the LFSR steps as phi2 ends.
module tia_hphase_gen #(
    parameter logic [5:0] WRAP = 6'h14,
    parameter logic [5:0] DEC  = 6'h3E
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       rsync,
    output logic       hphi1,
    output logic       hphi2,
    output logic [5:0] hcount,
    output logic       hwrap,
    output logic       hdec
);

    localparam logic [3:0] PH_INIT  = 4'b0001;
    localparam logic       WRAP_AT0 = (WRAP == 6'h00);
    localparam logic       DEC_AT0  = (DEC == 6'h00);

    logic [3:0] ph;
    logic [5:0] cnt_nxt;
    logic       step;

    // XNOR feedback; the all-ones lockup state is never entered from 00.
    always_comb begin
        cnt_nxt = {hcount[4:0], ~(hcount[5] ^ hcount[4])};
        if (hcount == WRAP) begin
            cnt_nxt = 6'h00;
        end
    end

    assign step  = run & ph[3];
    assign hphi1 = ph[1];
    assign hphi2 = ph[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph     <= PH_INIT;
            hcount <= 6'h00;
            hwrap  <= WRAP_AT0;
            hdec   <= DEC_AT0;
        end else if (rsync) begin
            ph     <= PH_INIT;
            hcount <= 6'h00;
            hwrap  <= WRAP_AT0;
            hdec   <= DEC_AT0;
        end else if (run) begin
            ph <= {ph[2:0], ph[3]};
            if (step) begin
                hcount <= cnt_nxt;
                hwrap  <= (cnt_nxt == WRAP);
                hdec   <= (cnt_nxt == DEC);
            end
        end
    end

endmodule

// File: tb/tb_tia_hphase_gen.sv
// Self-checking bench for tia_hphase_gen: directed vector table, hand sequences,
// and randomized run/rsync stimulus against a phase-index/sequence-table model.
module tb_tia_hphase_gen;

    localparam logic [5:0] WRAP = 6'h14;
    localparam logic [5:0] DEC  = 6'h3E;

    logic       clk;
    logic       reset;
    logic       run;
    logic       rsync;
    logic       hphi1;
    logic       hphi2;
    logic [5:0] hcount;
    logic       hwrap;
    logic       hdec;

    int tests;
    int fails;

    tia_hphase_gen #(.WRAP(WRAP), .DEC(DEC)) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .rsync (rsync),
        .hphi1 (hphi1),
        .hphi2 (hphi2),
        .hcount(hcount),
        .hwrap (hwrap),
        .hdec  (hdec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       rsync;
        logic       h1;
        logic       h2;
        logic [5:0] cnt;
    } vec_t;

    vec_t tbl[13];

    // Model: line sequence table plus phase index and position in the line.
    logic [5:0] seq[64];
    int         len;
    int         mph;
    int         midx;

    function automatic logic [5:0] lfsr_next(input logic [5:0] q);
        int b5;
        int b4;
        int v;
        b5 = (int'(q) / 32) % 2;
        b4 = (int'(q) / 16) % 2;
        v  = (int'(q) * 2) % 64 + ((b5 == b4) ? 1 : 0);
        return v[5:0];
    endfunction

    task automatic build_seq();
        len = 1;
        seq[0] = 6'h00;
        while (seq[len-1] != WRAP && len < 64) begin
            seq[len] = lfsr_next(seq[len-1]);
            len++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [5:0] c;
        c = seq[midx];
        check({tag, ".hphi1"}, int'(hphi1), (mph == 1) ? 1 : 0);
        check({tag, ".hphi2"}, int'(hphi2), (mph == 3) ? 1 : 0);
        check({tag, ".hcount"}, int'(hcount), int'(c));
        check({tag, ".hwrap"}, int'(hwrap), (c == WRAP) ? 1 : 0);
        check({tag, ".hdec"}, int'(hdec), (c == DEC) ? 1 : 0);
    endtask

    task automatic model_step(input logic r, input logic s);
        if (s) begin
            mph  = 0;
            midx = 0;
        end else if (r) begin
            if (mph == 3) midx = (midx + 1) % len;
            mph = (mph + 1) % 4;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b0;
        rsync = 1'b0;
        #2;
        reset = 1'b0;
        mph  = 0;
        midx = 0;
    endtask

    task automatic edge_chk(input logic r, input logic s, input string tag);
        run   = r;
        rsync = s;
        @(posedge clk);
        #1;
        model_step(r, s);
        check_model(tag);
    endtask

    task automatic edge_only(input logic r, input logic s);
        run   = r;
        rsync = s;
        @(posedge clk);
        #1;
        model_step(r, s);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        run   = 1'b0;
        rsync = 1'b0;
        build_seq();
        check("seq_no_lockup", int'(len < 64), 1);

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h01};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h01};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h00};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h00};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'h00};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00};

        // Reset is asynchronous: assert between edges and look before the next edge.
        #12;
        reset = 1'b1;
        #2;
        check("rst.hphi1", int'(hphi1), 0);
        check("rst.hphi2", int'(hphi2), 0);
        check("rst.hcount", int'(hcount), 0);
        check("rst.hwrap", int'(hwrap), 0);
        check("rst.hdec", int'(hdec), 0);
        reset = 1'b0;

        do_reset();
        for (int i = 0; i < 13; i++) begin
            run   = tbl[i].run;
            rsync = tbl[i].rsync;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.hphi1", i), int'(hphi1), int'(tbl[i].h1));
            check($sformatf("vec%0d.hphi2", i), int'(hphi2), int'(tbl[i].h2));
            check($sformatf("vec%0d.hcount", i), int'(hcount), int'(tbl[i].cnt));
            check($sformatf("vec%0d.hwrap", i), int'(hwrap), 0);
            check($sformatf("vec%0d.hdec", i), int'(hdec), 0);
        end

        // Early line: count steps every 4th edge, decode of 3E at edge 24.
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            edge_only(1'b1, 1'b0);
            if (e == 4)  check("e4.hcount", int'(hcount), 'h01);
            if (e == 8)  check("e8.hcount", int'(hcount), 'h03);
            if (e == 12) check("e12.hcount", int'(hcount), 'h07);
            if (e == 16) check("e16.hcount", int'(hcount), 'h0F);
            if (e == 20) check("e20.hcount", int'(hcount), 'h1F);
            if (e == 23) check("e23.hdec", int'(hdec), 0);
            if (e == 24) check("e24.hdec", int'(hdec), 1);
            if (e == 24) check("e24.hcount", int'(hcount), 'h3E);
        end

        // Async reset while hphi2=1 and hcount=1F, then release with no edge.
        do_reset();
        for (int e = 1; e <= 23; e++) edge_only(1'b1, 1'b0);
        check("pre_arst.hphi2", int'(hphi2), 1);
        check("pre_arst.hcount", int'(hcount), 'h1F);
        #2;
        reset = 1'b1;
        #1;
        check("arst.hphi2", int'(hphi2), 0);
        check("arst.hphi1", int'(hphi1), 0);
        check("arst.hcount", int'(hcount), 0);
        reset = 1'b0;
        mph  = 0;
        midx = 0;
        #1;
        check_model("arst_rel");
        edge_chk(1'b1, 1'b0, "arst_first");
        check("arst_first.hphi1", int'(hphi1), 1);

        // Two full lines of free running; wrap at the last state of each line.
        do_reset();
        for (int e = 1; e <= 8 * len; e++) begin
            edge_chk(1'b1, 1'b0, "free");
            if (e == 4 * (len - 1) || e == 8 * len - 4) begin
                check("free.wrap_cnt", int'(hcount), int'(WRAP));
                check("free.wrap_flag", int'(hwrap), 1);
            end
            if (e == 4 * len || e == 8 * len) begin
                check("free.line_cnt", int'(hcount), 0);
                check("free.line_flag", int'(hwrap), 0);
            end
        end

        // Randomized run/rsync against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            edge_chk(($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
